// File: rtl/cache_mem_arbiter.sv
// Shared-RAM arbiter for icache/dcache misses: dcache first, icache forced after
// STARVE_MAX back-to-back dcache grants while it waits. RAM strobes are registered.
module cache_mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int WORD_W     = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              i_ren,
  input  logic [WORD_W-1:0] i_addr,
  output logic              i_wait,
  output logic [WORD_W-1:0] i_load,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_store,
  output logic              d_wait,
  output logic [WORD_W-1:0] d_load,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [WORD_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_store,
  input  logic [WORD_W-1:0] ram_load,
  input  logic              ram_ready
);

  // state | meaning:  IDLE | arbitrate ; I_ACC | icache fetch on RAM ; D_ACC | dcache load/store on RAM
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] I_ACC = 2'd1;
  localparam logic [1:0] D_ACC = 2'd2;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic [1:0]        state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              wen_q, wen_d;
  logic              ram_ren_q, ram_ren_d;
  logic              ram_wen_q, ram_wen_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] store_q, store_d;

  logic d_req, i_done, d_done;

  assign d_req  = d_ren | d_wen;
  assign i_done = (state_q == I_ACC) & ram_ready;
  assign d_done = (state_q == D_ACC) & ram_ready;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    store_d  = store_q;
    case (state_q)
      IDLE: begin
        if (d_req && !(i_ren && starve_q == SMAX)) begin
          state_d = D_ACC;
          wen_d   = d_wen;
          addr_d  = d_addr;
          store_d = d_store;
          if (i_ren && starve_q != SMAX) starve_d = starve_q + 4'd1;
        end else if (i_ren) begin
          state_d  = I_ACC;
          addr_d   = i_addr;
          starve_d = 4'd0;
        end else begin
          starve_d = 4'd0;
        end
      end
      I_ACC, D_ACC: if (ram_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Strobes follow the state being entered so they line up with it after the edge.
    ram_ren_d = (state_d == I_ACC) | ((state_d == D_ACC) & ~wen_d);
    ram_wen_d = (state_d == D_ACC) & wen_d;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= IDLE;
      starve_q  <= 4'd0;
      wen_q     <= 1'b0;
      ram_ren_q <= 1'b0;
      ram_wen_q <= 1'b0;
      addr_q    <= '0;
      store_q   <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      wen_q     <= wen_d;
      ram_ren_q <= ram_ren_d;
      ram_wen_q <= ram_wen_d;
      addr_q    <= addr_d;
      store_q   <= store_d;
    end
  end

  assign i_wait    = i_ren & ~i_done;
  assign d_wait    = d_req & ~d_done;
  assign i_load    = i_done ? ram_load : '0;
  assign d_load    = (d_done & ~wen_q) ? ram_load : '0;
  assign ram_ren   = ram_ren_q;
  assign ram_wen   = ram_wen_q;
  assign ram_addr  = addr_q;
  assign ram_store = store_q;

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sits between the icache/dcache miss paths and the single shared RAM port. Serialises instruction fetches and data loads/stores onto that port.
- Dcache has priority; a bounded-starvation counter guarantees icache forward progress.
- Requesters see a wait/load handshake; the RAM side sees registered strobes and a ready return.

Parameters:
- STARVE_MAX, 4: consecutive dcache grants allowed while icache is pending before icache is forced. Range 1..15.
- WORD_W, 32: data/address width (word_t).

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  synchronous active-low reset
- i_ren  in  1  icache read request, held until i_wait low
- i_addr  in  WORD_W  icache fetch address
- i_wait  out  1  icache stall
- i_load  out  WORD_W  fetched word, valid when i_ren & !i_wait
- d_ren  in  1  dcache read request
- d_wen  in  1  dcache write request
- d_addr  in  WORD_W  dcache address
- d_store  in  WORD_W  dcache write data
- d_wait  out  1  dcache stall
- d_load  out  WORD_W  read word, valid when d_ren & !d_wait
- ram_ren  out  1  RAM read strobe, registered
- ram_wen  out  1  RAM write strobe, registered
- ram_addr  out  WORD_W  RAM address, registered
- ram_store  out  WORD_W  RAM write data, registered
- ram_load  in  WORD_W  RAM read data
- ram_ready  in  1  RAM access complete this cycle

Behaviour:
- Reset (nRST low at CLK edge): state IDLE; starve_cnt=0; ram_ren=ram_wen=0; ram_addr=ram_store=0. i_wait/d_wait then follow the combinational rules below; i_load=d_load=0 outside completion cycles.
- States: IDLE, I_ACC, D_ACC.
- IDLE grant (evaluated every cycle):
  - d_req = d_ren|d_wen.
  - If d_req and !(i_ren & starve_cnt==STARVE_MAX): go to D_ACC. Latch d_addr, d_store, and wen=d_wen. If d_ren&d_wen, the access is a write. If i_ren, starve_cnt++, saturating at STARVE_MAX.
  - Else if i_ren: go to I_ACC. Latch i_addr; starve_cnt=0.
  - Else: stay IDLE; starve_cnt=0.
- I_ACC: ram_ren=1, ram_wen=0, ram_addr=latched address.
- D_ACC: ram_ren=!wen, ram_wen=wen; ram_addr and ram_store are the latched values.
- Strobes are registered: they become valid in the first cycle of the access state and clear on the edge leaving it.
- Completion: in X_ACC with ram_ready=1, same cycle:
  - x_wait=0; x_load=ram_load (d_load=0 for writes).
  - Next state is IDLE.
  - Only ram_ready is sampled; in IDLE it is ignored.
- Wait rules (combinational):
  - i_wait = i_ren & !(state==I_ACC & ram_ready).
  - d_wait = d_req & !(state==D_ACC & ram_ready).
- Latency: request first seen in IDLE at cycle 0; strobe at cycle 1; earliest completion at cycle 1. Throughput is at most one access per 2 cycles; back-to-back requests always pass through IDLE.
- Requester drop mid-access (x_ren low before ram_ready): the access still runs to ram_ready, the result is discarded, and no new grant is made until IDLE.
- Address or data changing mid-access has no effect, because the values are latched.
- Simultaneous i_ren & d_req in IDLE: dcache wins unless starve_cnt==STARVE_MAX, in which case icache wins.
- Reset mid-access: abort; IDLE next edge; strobes low next edge; the pending request is re-arbitrated after reset.
- Never: ram_ren&ram_wen both 1; any strobe high in IDLE; two grants outstanding.

Test Plan:
- Single fetch: reset, then i_ren=1, i_addr=0x100, RAM ready 2 cycles after strobe, ram_load=0xDEADBEEF -> ram_ren high 2 cycles with ram_addr=0x100; i_wait low only in the ready cycle with i_load=0xDEADBEEF.
- Dcache write: d_wen=1, d_addr=0x200, d_store=0x12345678, ram_ready on first strobe cycle -> ram_wen=1 for 1 cycle with latched values; d_wait low in that cycle; ram_ren stays 0.
- Contention plus starvation (STARVE_MAX=4): i_ren held, d_ren re-requested every IDLE -> grant order D,D,D,D,I,D…; starve_cnt resets after the I grant; i_wait high throughout the first four accesses.
- Both d_ren&d_wen with i_ren idle -> write performed (ram_wen=1, ram_ren=0).
- Request drop: i_ren deasserted one cycle after grant, ram_ready 3 cycles later -> access completes, state returns to IDLE, and a d_ren pending meanwhile is granted the following cycle.
- Reset mid-access: nRST low during D_ACC before ram_ready -> ram_wen=0 and state IDLE after the edge; with d_wen still high after release, the write re-issues from scratch.
